pool_scheduler: RTL

Round-robin scheduler that shares one pooling engine between `NUM_REQ` requesters, such as convolution output buffers. It arbitrates pending requests and latches the winner's pool type and kernel count. It then sequences the engine one kernel at a time with a start/done handshake and returns a per-requester completion pulse. It sits between the convolution stage outputs and the single pooling datapath instance.

---
 rtl/npu_pool_pkg.sv | 14 +
 rtl/pool_scheduler_rr_arbiter.sv | 36 +++
 rtl/pool_scheduler.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/npu_pool_pkg.sv
// Types shared by the pooling scheduler and the pooling datapath.
package npu_pool_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } pool_sched_state_t;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

endpackage

// File: rtl/pool_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/pool_scheduler.sv
// Round-robin owner of the shared pooling engine; one kernel per start/done.
// Define POOL_SCHED_TIMEOUT_EN to add the WAIT watchdog and timeout_err.
module pool_scheduler
    import npu_pool_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MAX_KERNELS = 8,
    parameter int KCW         = $clog2(MAX_KERNELS + 1)
`ifdef POOL_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_pool_type,
    input  logic [NUM_REQ*KCW-1:0]     req_kernels,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic [NUM_REQ-1:0]         resp_done,
    output logic                       eng_start,
    output logic                       eng_pool_type,
    output logic [KCW-1:0]             eng_kernel_id,
    input  logic                       eng_kernel_done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef POOL_SCHED_TIMEOUT_EN
    ,
    output logic                       timeout_err
`endif
);

    localparam int GW = $clog2(NUM_REQ);

    pool_sched_state_t r_state, w_state_nxt;

    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic               r_start, w_start_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_ptype, w_ptype_nxt;
    logic [GW-1:0]      r_gid, w_gid_nxt;
    logic [GW-1:0]      r_ptr, w_ptr_nxt;
    logic [KCW-1:0]     r_cnt, w_cnt_nxt;
    logic [KCW-1:0]     r_kidx, w_kidx_nxt;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [GW-1:0]      w_arb_idx;
    logic               w_arb_valid;
    logic [KCW-1:0]     w_req_raw;
    logic [KCW-1:0]     w_req_cnt;
    logic [KCW-1:0]     w_kidx_inc;
    logic [NUM_REQ-1:0] w_gid_oh;
    logic               w_abort;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (GW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_req_raw  = req_kernels[int'(w_arb_idx)*KCW +: KCW];
    assign w_req_cnt  = (w_req_raw > KCW'(MAX_KERNELS)) ?
                        KCW'(MAX_KERNELS) : w_req_raw;
    assign w_kidx_inc = r_kidx + KCW'(1);
    assign w_gid_oh   = NUM_REQ'(1) << r_gid;

`ifdef POOL_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tcnt;
    logic          r_terr;

    // r_tcnt counts cycles since eng_start, so TIMEOUT_CYCLES maps to resp_done
    assign w_abort = (r_state == ST_WAIT) && !eng_kernel_done &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            if (w_start_nxt) begin
                r_tcnt <= TW'(1);
            end else if ((r_state == ST_RUN || r_state == ST_WAIT) &&
                         r_tcnt != TW'(TIMEOUT_CYCLES)) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
            if (w_abort) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = '0;
        w_done_nxt  = '0;
        w_start_nxt = 1'b0;
        w_busy_nxt  = r_busy;
        w_ptype_nxt = r_ptype;
        w_gid_nxt   = r_gid;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_kidx_nxt  = r_kidx;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_ack_nxt   = w_arb_grant;
                    w_busy_nxt  = 1'b1;
                    w_gid_nxt   = w_arb_idx;
                    w_ptype_nxt = req_pool_type[w_arb_idx];
                    w_cnt_nxt   = w_req_cnt;
                    w_kidx_nxt  = '0;
                    w_ptr_nxt   = (w_arb_idx == GW'(NUM_REQ - 1)) ?
                                  '0 : w_arb_idx + GW'(1);
                    if (w_req_cnt == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_start_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_kernel_done) begin
                    if (w_kidx_inc < r_cnt) begin
                        w_kidx_nxt  = w_kidx_inc;
                        w_state_nxt = ST_RUN;
                        w_start_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = w_gid_oh;
                    end
                end else if (w_abort) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = w_gid_oh;
                end
            end
            ST_DONE: begin
                // a zero-count job arrives here without the pulse issued yet
                if (|r_done) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_done_nxt = w_gid_oh;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_ptype <= POOL_MAX;
            r_gid   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_kidx  <= '0;
        end else begin
            r_ack   <= w_ack_nxt;
            r_done  <= w_done_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_ptype <= w_ptype_nxt;
            r_gid   <= w_gid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_kidx  <= w_kidx_nxt;
        end
    end

    assign req_ack       = r_ack;
    assign resp_done     = r_done;
    assign eng_start     = r_start;
    assign eng_pool_type = r_ptype;
    assign eng_kernel_id = r_kidx;
    assign busy          = r_busy;
    assign grant_id      = r_gid;

endmodule
